// File: rtl/gd_pkg.sv
// Shared widths and FSM state type for the gradient-descent sweep controller.
package gd_pkg;

  localparam int X_W       = 32;
  localparam int Y_W       = 64;
  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE
  } sweep_state_e;

endpackage

// File: rtl/gd_best_tracker.sv
// Running-minimum register for a sweep: keeps the first point, then any strictly smaller y.
module gd_best_tracker
  import gd_pkg::*;
#(
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             first_i,
  input  logic             update_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [X_W-1:0]   x_i,
  input  logic [Y_W-1:0]   y_i,
  output logic [IDX_W-1:0] best_index_o,
  output logic [X_W-1:0]   best_x_o,
  output logic [Y_W-1:0]   best_y_o
);

  logic [IDX_W-1:0] best_index_q;
  logic [X_W-1:0]   best_x_q;
  logic [Y_W-1:0]   best_y_q;
  logic             take;

  // Strict less-than so a tie leaves the earlier index in place.
  assign take = update_i && (first_i || ($signed(y_i) < $signed(best_y_q)));

  always_ff @(posedge clk) begin
    if (clear_i) begin
      best_index_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else if (take) begin
      best_index_q <= idx_i;
      best_x_q     <= x_i;
      best_y_q     <= y_i;
    end
  end

  assign best_index_o = best_index_q;
  assign best_x_o     = best_x_q;
  assign best_y_o     = best_y_q;

endmodule

// File: rtl/gd_sweep_controller.sv
// Drives the core start_op/done_op handshake over NUM_POINTS descending starting points.
// Optional watchdog enabled by defining GD_SWEEP_TIMEOUT_EN.
module gd_sweep_controller
  import gd_pkg::*;
#(
  parameter int             NUM_POINTS     = 10,
  parameter logic [X_W-1:0] X_STEP         = X_W'(1) << FRAC_BITS,
  parameter int             TIMEOUT_CYCLES = 4096,
  localparam int            IDX_W          = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sweep_start,
  input  logic [X_W-1:0]   x_start,
  output logic             core_start_op,
  output logic [X_W-1:0]   core_x_init,
  input  logic [X_W-1:0]   core_x_at_min,
  input  logic [Y_W-1:0]   core_y_min,
  input  logic             core_done_op,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_index,
  output logic [X_W-1:0]   res_x_init,
  output logic [X_W-1:0]   res_x_at_min,
  output logic [Y_W-1:0]   res_y_min,
  output logic [IDX_W-1:0] best_index,
  output logic [X_W-1:0]   best_x_at_min,
  output logic [Y_W-1:0]   best_y_min,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             timeout_err
);

  if (NUM_POINTS < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("gd_sweep_controller: NUM_POINTS and TIMEOUT_CYCLES must be at least 1");
  end

  sweep_state_e     state_q;
  logic [IDX_W-1:0] k_q;
  logic [X_W-1:0]   x_q, x_d;
  logic             start_q, res_valid_q, busy_q, done_q;
  logic [IDX_W-1:0] res_index_q;
  logic [X_W-1:0]   res_x_init_q, res_x_at_min_q;
  logic [Y_W-1:0]   res_y_min_q;
  logic             last_point, accept, capture, progress, timeout_fire;

  assign x_d        = x_q - X_STEP;
  assign last_point = (k_q == IDX_W'(NUM_POINTS - 1));
  // The sweep_done cycle is already IDLE, but a request landing there is still refused.
  assign accept     = (state_q == IDLE) && sweep_start && !done_q;
  assign capture    = (state_q == ISSUE) && core_done_op;
  assign progress   = capture || ((state_q == RELEASE) && !core_done_op);

`ifdef GD_SWEEP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;

  // A handshake step on the limit cycle wins over the watchdog.
  assign timeout_fire = (state_q != IDLE) && !progress &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE || progress || timeout_fire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_fire) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      x_q            <= '0;
      start_q        <= 1'b0;
      res_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      res_index_q    <= '0;
      res_x_init_q   <= '0;
      res_x_at_min_q <= '0;
      res_y_min_q    <= '0;
    end else begin
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            k_q     <= '0;
            x_q     <= x_start;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (timeout_fire) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (core_done_op) begin
            start_q        <= 1'b0;
            res_valid_q    <= 1'b1;
            res_index_q    <= k_q;
            res_x_init_q   <= x_q;
            res_x_at_min_q <= core_x_at_min;
            res_y_min_q    <= core_y_min;
            state_q        <= RELEASE;
          end
        end
        RELEASE: begin
          if (timeout_fire) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (!core_done_op) begin
            if (last_point) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              k_q     <= k_q + 1'b1;
              x_q     <= x_d;
              start_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  gd_best_tracker #(
    .IDX_W(IDX_W)
  ) u_best (
    .clk         (clk),
    .clear_i     (rst),
    .first_i     (k_q == '0),
    .update_i    (capture),
    .idx_i       (k_q),
    .x_i         (core_x_at_min),
    .y_i         (core_y_min),
    .best_index_o(best_index),
    .best_x_o    (best_x_at_min),
    .best_y_o    (best_y_min)
  );

  assign core_start_op = start_q;
  assign core_x_init   = x_q;
  assign res_valid     = res_valid_q;
  assign res_index     = res_index_q;
  assign res_x_init    = res_x_init_q;
  assign res_x_at_min  = res_x_at_min_q;
  assign res_y_min     = res_y_min_q;
  assign sweep_busy    = busy_q;
  assign sweep_done    = done_q;

endmodule

// File: tb/tb_gd_sweep_controller.sv
// Bench for gd_sweep_controller against a stub core; watchdog case runs when GD_SWEEP_TIMEOUT_EN is defined.
module tb_gd_sweep_controller;

  localparam int NUM_POINTS = 3;
  localparam int IDX_W      = 2;

  logic             clk;
  logic             rst;
  logic             sweep_start;
  logic [31:0]      x_start;
  logic             core_start_op;
  logic [31:0]      core_x_init;
  logic             res_valid;
  logic [IDX_W-1:0] res_index;
  logic [31:0]      res_x_init, res_x_at_min;
  logic [63:0]      res_y_min;
  logic [IDX_W-1:0] best_index;
  logic [31:0]      best_x_at_min;
  logic [63:0]      best_y_min;
  logic             sweep_busy, sweep_done, timeout_err;

  // Stub core state
  logic        stubDone  = 1'b0;
  logic [31:0] stubX     = '0;
  logic [63:0] stubY     = '0;
  int          hiCnt     = 0;
  int          loCnt     = 0;
  int          ptIdx     = 0;
  int          stubD     = 4;
  int          stubHold  = 2;
  bit          stubNever = 1'b0;
  bit          stubClear = 1'b0;
  logic [63:0] yTab [3];

  int checkCount = 0;
  int failCount  = 0;

  logic anyOut;

  gd_sweep_controller #(
    .NUM_POINTS    (NUM_POINTS),
    .X_STEP        (32'h00000100),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sweep_start  (sweep_start),
    .x_start      (x_start),
    .core_start_op(core_start_op),
    .core_x_init  (core_x_init),
    .core_x_at_min(stubX),
    .core_y_min   (stubY),
    .core_done_op (stubDone),
    .res_valid    (res_valid),
    .res_index    (res_index),
    .res_x_init   (res_x_init),
    .res_x_at_min (res_x_at_min),
    .res_y_min    (res_y_min),
    .best_index   (best_index),
    .best_x_at_min(best_x_at_min),
    .best_y_min   (best_y_min),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .timeout_err  (timeout_err)
  );

  assign anyOut = |{core_start_op, core_x_init, res_valid, res_index, res_x_init,
                    res_x_at_min, res_y_min, best_index, best_x_at_min, best_y_min,
                    sweep_busy, sweep_done, timeout_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub: done rises stubD cycles after start_op rises, falls stubHold cycles after it falls.
  always @(posedge clk) begin
    if (stubClear) ptIdx <= 0;
    if (core_start_op) begin
      loCnt <= 0;
      if (!stubDone && !stubNever) begin
        if (hiCnt + 1 >= stubD) begin
          stubDone <= 1'b1;
          hiCnt    <= 0;
          stubX    <= core_x_init ^ 32'h55;
          stubY    <= (ptIdx < 3) ? yTab[ptIdx] : 64'h0;
          ptIdx    <= ptIdx + 1;
        end else begin
          hiCnt <= hiCnt + 1;
        end
      end
    end else begin
      hiCnt <= 0;
      if (stubDone) begin
        if (loCnt + 1 >= stubHold) begin
          stubDone <= 1'b0;
          loCnt    <= 0;
        end else begin
          loCnt <= loCnt + 1;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] xStart;
    logic [63:0] y0, y1, y2;
    int          d;
    int          hold;
    bit          injectBusy;
    logic [31:0] x0, x1, x2;
    logic [1:0]  bestIdx;
    logic [31:0] bestX;
    logic [63:0] bestY;
  } sweepVec_t;

  sweepVec_t vecs [4];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input sweepVec_t v);
    logic [31:0] expX [3];
    logic [63:0] expY [3];
    int resCnt, lowRun, extraDone;
    bit prevStart, finished, anyStart, anyBusy;
    expX[0] = v.x0; expX[1] = v.x1; expX[2] = v.x2;
    expY[0] = v.y0; expY[1] = v.y1; expY[2] = v.y2;
    yTab[0] = v.y0; yTab[1] = v.y1; yTab[2] = v.y2;
    stubD = v.d;
    stubHold = v.hold;
    stubClear = 1'b1;
    @(negedge clk);
    stubClear = 1'b0;
    x_start = v.xStart;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    x_start = '0;
    checkOutput("startLatency", core_start_op, 1);
    checkOutput("busyAfterAccept", sweep_busy, 1);
    checkOutput("xInitFirst", core_x_init, expX[0]);
    resCnt = 0;
    lowRun = 0;
    prevStart = 1'b1;
    finished = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (v.injectBusy && cyc == 1) begin
        sweep_start = 1'b1;
        x_start = 32'hDEAD0000;
      end else if (v.injectBusy && cyc == 2) begin
        sweep_start = 1'b0;
        x_start = '0;
      end
      @(negedge clk);
      lowRun = stubDone ? 0 : lowRun + 1;
      if (core_start_op && !prevStart) begin
        if (resCnt < 3) checkOutput("xInitNext", core_x_init, expX[resCnt]);
        checkOutput("reissueGap", lowRun, 2);
      end
      prevStart = core_start_op;
      if (res_valid) begin
        if (resCnt >= 3) begin
          checkOutput("extraResValid", resCnt, 2);
        end else begin
          checkOutput("resIndex", res_index, resCnt);
          checkOutput("resXInit", res_x_init, expX[resCnt]);
          checkOutput("resXAtMin", res_x_at_min, expX[resCnt] ^ 32'h55);
          checkOutput("resYMin", res_y_min, expY[resCnt]);
          checkOutput("startDropOnCapture", core_start_op, 0);
        end
        resCnt++;
      end
      if (sweep_done) begin
        finished = 1'b1;
        checkOutput("resCount", resCnt, 3);
        checkOutput("busyAtDone", sweep_busy, 0);
        checkOutput("bestIndex", best_index, v.bestIdx);
        checkOutput("bestX", best_x_at_min, v.bestX);
        checkOutput("bestY", best_y_min, v.bestY);
        checkOutput("timeoutClear", timeout_err, 0);
      end
    end
    checkOutput("sweepDoneSeen", finished, 1);
    if (v.injectBusy) begin
      sweep_start = 1'b1;
      x_start = 32'hDEAD0000;
    end
    anyStart = 1'b0;
    anyBusy = 1'b0;
    extraDone = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      sweep_start = 1'b0;
      x_start = '0;
      anyStart |= core_start_op;
      anyBusy |= sweep_busy;
      if (sweep_done) extraDone++;
    end
    checkOutput("noRestart", anyStart, 0);
    checkOutput("idleBusy", anyBusy, 0);
    checkOutput("donePulseOnce", extraDone, 0);
  endtask

  task automatic resetMidSweep();
    bit reached;
    int resSeen;
    yTab[0] = 64'h50; yTab[1] = 64'h10; yTab[2] = 64'h10;
    stubD = 4;
    stubHold = 2;
    stubClear = 1'b1;
    @(negedge clk);
    stubClear = 1'b0;
    x_start = 32'h200;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    reached = 1'b0;
    resSeen = 0;
    for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
      @(negedge clk);
      if (res_valid) resSeen++;
      if (resSeen > 0 && core_start_op) reached = 1'b1;
    end
    checkOutput("midSweepReached", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstDropsStart", core_start_op, 0);
    checkOutput("rstOutputsZero", anyOut, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstZero", anyOut, 0);
    repeat (10) @(negedge clk);
    checkOutput("postRstIdle", core_start_op | sweep_busy, 0);
  endtask

`ifdef GD_SWEEP_TIMEOUT_EN
  task automatic watchdogTest();
    int resCnt, doneCnt;
    stubNever = 1'b1;
    x_start = 32'h300;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    resCnt = 0;
    doneCnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (res_valid) resCnt++;
      if (sweep_done) doneCnt++;
    end
    checkOutput("wdTimeoutErr", timeout_err, 1);
    checkOutput("wdDoneOnce", doneCnt, 1);
    checkOutput("wdNoResValid", resCnt, 0);
    checkOutput("wdStartLow", core_start_op, 0);
    checkOutput("wdBusyLow", sweep_busy, 0);
    stubNever = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    sweep_start = 1'b0;
    x_start = '0;
    yTab[0] = '0; yTab[1] = '0; yTab[2] = '0;

    vecs[0] = '{xStart: 32'h200, y0: 64'h50, y1: 64'h10, y2: 64'h10, d: 4, hold: 2,
                injectBusy: 1'b0, x0: 32'h200, x1: 32'h100, x2: 32'h000,
                bestIdx: 2'd1, bestX: 32'h155, bestY: 64'h10};
    vecs[1] = '{xStart: 32'h80000000, y0: 64'h5, y1: 64'h5, y2: 64'h5, d: 1, hold: 2,
                injectBusy: 1'b1, x0: 32'h80000000, x1: 32'h7FFFFF00, x2: 32'h7FFFFE00,
                bestIdx: 2'd0, bestX: 32'h80000055, bestY: 64'h5};
    vecs[2] = '{xStart: 32'h0, y0: 64'hFFFFFFFFFFFFFFFF, y1: 64'h3, y2: 64'h8000000000000000,
                d: 2, hold: 1, injectBusy: 1'b0, x0: 32'h0, x1: 32'hFFFFFF00, x2: 32'hFFFFFE00,
                bestIdx: 2'd2, bestX: 32'hFFFFFE55, bestY: 64'h8000000000000000};
    vecs[3] = '{xStart: 32'h100, y0: 64'h30, y1: 64'h20, y2: 64'h10, d: 3, hold: 6,
                injectBusy: 1'b0, x0: 32'h100, x1: 32'h0, x2: 32'hFFFFFF00,
                bestIdx: 2'd2, bestX: 32'hFFFFFF55, bestY: 64'h10};

    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", anyOut, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", anyOut, 0);

`ifdef GD_SWEEP_TIMEOUT_EN
    watchdogTest();
`endif

    for (int i = 0; i < 4; i++) begin
      $display("[TB] sweep vector %0d", i);
      applyStimulus(vecs[i]);
    end

    resetMidSweep();

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/gd_sweep_controller.md
# gd_sweep_controller

Initiator side of the gradient-descent core's `start_op`/`done_op` level handshake. It runs a sweep of `NUM_POINTS` starting points `x_k = x_start - k*X_STEP` (Q24.8) through the core, one at a time. For every point it reports the core's result, and across the sweep it tracks the overall minimum. It sits beside `Top` and takes over, in RTL, the job the sweep bench did in simulation.

## Interface
- `NUM_POINTS`, 10: number of starting points per sweep, at least 1.
- `X_STEP`, 32'h00000100: signed Q24.8 decrement between points (1.0).
- `TIMEOUT_CYCLES`, 4096: watchdog limit. Used only when `GD_SWEEP_TIMEOUT_EN` is defined.
- `IDX_W` is a localparam equal to `max(1, $clog2(NUM_POINTS))`.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sweep_start` in 1: sweep request. Sampled only in IDLE.
- `x_start` in 32: signed Q24.8 first point. Sampled together with `sweep_start`.
- `core_start_op` out 1: connects to core `start_op`.
- `core_x_init` out 32: connects to core `x_init`.
- `core_x_at_min` in 32: core result x, Q24.8.
- `core_y_min` in 64: core result y, Q56.8.
- `core_done_op` in 1: core completion level.
- `res_valid` out 1: one-cycle pulse for each completed point.
- `res_index` out IDX_W: point index k.
- `res_x_init`, `res_x_at_min` out 32, and `res_y_min` out 64: per-point results.
- `best_index` out IDX_W, `best_x_at_min` out 32, `best_y_min` out 64: running minimum.
- `sweep_busy` out 1: high from the cycle after a request is accepted until the controller returns to IDLE.
- `sweep_done` out 1: one-cycle pulse when the sweep ends.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States and transitions:
  - IDLE: when `sweep_start`=1, load `k`=0 and `core_x_init`=`x_start`, clear `timeout_err`, then go to ISSUE.
  - ISSUE: drive `core_start_op`=1. When `core_done_op`=1 is sampled, latch the `res_*` values from the core, pulse `res_valid`, update the best-result registers, and go to RELEASE.
  - RELEASE: drive `core_start_op`=0. When `core_done_op`=0 is sampled:
    - if `k`=NUM_POINTS-1, pulse `sweep_done` and go to IDLE;
    - otherwise set `k`+=1 and `core_x_init` -= `X_STEP`, then go to ISSUE.
- `core_x_init` is stable for all of ISSUE and RELEASE for a point. It only changes on the RELEASE-to-ISSUE transition.
- x arithmetic is 32-bit two's complement and wraps with no saturation. Example: 0x80000000 - 0x100 = 0x7FFFFF00.
- Best-result tracking:
  - point 0 is always taken;
  - a later point replaces the stored best only if its `core_y_min` is strictly less, as a signed 64-bit compare;
  - on a tie the earlier index is kept.
- `sweep_start` is ignored while not in IDLE, including during the `sweep_done` cycle.
- `res_*` and `best_*` hold their values until they are overwritten. `best_*` is valid from `sweep_done` until the next accepted sweep.
- A new `core_start_op` is never raised while `core_done_op` is still high.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset in the middle of a sweep drops `core_start_op` at the next edge and abandons the sweep.
- Request to core: `sweep_start` sampled at edge N gives `core_start_op`=1 from edge N+1.
- Result capture: `core_done_op` first sampled high at edge M gives `res_valid`=1 and `core_start_op`=0 in the cycle after M.
- Point-to-point: `core_done_op` sampled low at edge R gives the next `core_start_op`=1 in the cycle after R.
- Per-point overhead is therefore 2 cycles plus the core's own handshake latency.
- End of sweep: `sweep_done` is asserted in the cycle after the final RELEASE exit, in which `sweep_busy` is 0.

## Configuration
- `GD_SWEEP_TIMEOUT_EN` defined:
  - a cycle counter runs in ISSUE and RELEASE and is cleared on every state change;
  - when it reaches `TIMEOUT_CYCLES`, the controller drops `core_start_op`, sets `timeout_err`=1, pulses `sweep_done` and returns to IDLE;
  - no `res_valid` is generated for the timed-out point.
- Not defined: no counter is built, `timeout_err` is tied 0, and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `gd_pkg` holds:
  - widths `X_W`=32, `Y_W`=64, `FRAC_BITS`=8;
  - the state enum: IDLE, ISSUE, RELEASE.
- One sub-module, `gd_best_tracker`: clear/first/update inputs, signed strict-less compare, and holds `best_index`, `best_x_at_min` and `best_y_min`.

## Test plan
The bench uses a stub core: `done_op` rises D cycles after `start_op` and falls 2 cycles after `start_op` falls.
- Reset: hold `rst` for 3 cycles mid-sweep. All outputs are 0 on the next cycle and `core_start_op` is 0.
- Sweep values: NUM_POINTS=3, X_STEP=0x100, x_start=0x200, D=4.
  - `core_x_init` takes the values 0x200, 0x100, 0x000.
  - Exactly 3 `res_valid` pulses with indices 0, 1, 2, then one `sweep_done`.
- Best tracking: the stub returns `y_min` of 0x50, then 0x10, then 0x10. The result is `best_index`=1 and `best_y_min`=0x10, so the tie keeps the earlier index.
- Handshake: the stub holds `done_op` high for 6 cycles after `start_op` falls. The controller stays in RELEASE, and the next `start_op` rises exactly one cycle after `done_op` is sampled low.
- Busy and wrap:
  - pulsing `sweep_start` during ISSUE is ignored, so only 3 points run;
  - x_start=0x80000000 gives 0x80000000, then 0x7FFFFF00 on the second point.
- Watchdog: with `GD_SWEEP_TIMEOUT_EN`, TIMEOUT_CYCLES=16 and a stub that never asserts `done_op`, `timeout_err`=1, `sweep_done` pulses once, and no `res_valid` is generated.
